// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative Q2.13 divider.
package div_pkg;

   localparam int DIV_WIDTH = 16;
   localparam int DIV_FRAC  = 13;
   localparam int ITER      = DIV_WIDTH + DIV_FRAC;

   localparam logic [15:0] Q_MAX = 16'h7FFF;
   localparam logic [15:0] Q_MIN = 16'h8000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift in a numerator bit, subtract the divisor if it fits.
module div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] dvs,
   input  logic             bit_in,
   output logic [WIDTH-1:0] rem_nxt,
   output logic             q_bit
);

   logic [WIDTH:0] trial;

   // With a non-zero divisor the remainder stays below it, so WIDTH bits hold the result.
   assign trial   = {rem, bit_in};
   assign q_bit   = (trial >= {1'b0, dvs});
   assign rem_nxt = q_bit ? WIDTH'(trial - {1'b0, dvs}) : trial[WIDTH-1:0];

endmodule

// File: rtl/divider_16.sv
// Iterative signed Q2.13 divider: restoring division on magnitudes, one quotient bit
// per cycle, sign applied and saturated as the last bit is produced.
module divider_16
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int FRAC  = DIV_FRAC
) (
   input  logic             I_CLK,
   input  logic             I_RST,
   input  logic             I_VLD,
   input  logic [WIDTH-1:0] I_DIVIDEND,
   input  logic [WIDTH-1:0] I_DIVISOR,
   output logic             O_VLD,
   output logic             O_DIV_BUSY,
   output logic [WIDTH-1:0] O_QUOTIENT,
   output logic             O_DZ
);

   localparam int ITER_L = WIDTH + FRAC;
   localparam int CW     = $clog2(ITER_L);

   state_t             state, state_nxt;
   logic [ITER_L-1:0]  numer;
   logic [ITER_L-2:0]  quo;
   logic [ITER_L-1:0]  quo_fin;
   logic [WIDTH-1:0]   rem, rem_nxt, dvs_mag;
   logic [WIDTH-1:0]   dvd_abs, dvs_abs, result;
   logic [CW-1:0]      cnt;
   logic               sign, dvd_neg, dz, q_bit, last_step;

   assign dvd_abs = I_DIVIDEND[WIDTH-1] ? (~I_DIVIDEND + WIDTH'(1)) : I_DIVIDEND;
   assign dvs_abs = I_DIVISOR[WIDTH-1]  ? (~I_DIVISOR  + WIDTH'(1)) : I_DIVISOR;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem     (rem),
      .dvs     (dvs_mag),
      .bit_in  (numer[ITER_L-1]),
      .rem_nxt (rem_nxt),
      .q_bit   (q_bit)
   );

   assign quo_fin   = {quo, q_bit};
   assign last_step = (state == CALC) && (cnt == CW'(ITER_L - 1));

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      result = '0;
      if (dz)
         result = dvd_neg ? WIDTH'(Q_MIN) : WIDTH'(Q_MAX);
      else if (!sign)
         result = (quo_fin > ITER_L'(Q_MAX)) ? WIDTH'(Q_MAX) : quo_fin[WIDTH-1:0];
      else
         result = (quo_fin >= ITER_L'(Q_MIN)) ? WIDTH'(Q_MIN) : (~quo_fin[WIDTH-1:0] + WIDTH'(1));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (I_VLD) state_nxt = CALC;
         CALC:    if (last_step) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: the datapath is a handful of flops, not a memory, so every one is reset.
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         numer      <= '0;
         quo        <= '0;
         rem        <= '0;
         dvs_mag    <= '0;
         cnt        <= '0;
         sign       <= 1'b0;
         dvd_neg    <= 1'b0;
         dz         <= 1'b0;
         O_QUOTIENT <= '0;
         O_DZ       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (I_VLD) begin
               numer   <= {dvd_abs, {FRAC{1'b0}}};
               dvs_mag <= dvs_abs;
               sign    <= I_DIVIDEND[WIDTH-1] ^ I_DIVISOR[WIDTH-1];
               dvd_neg <= I_DIVIDEND[WIDTH-1];
               dz      <= (I_DIVISOR == '0);
               rem     <= '0;
               quo     <= '0;
               cnt     <= '0;
            end
            CALC: begin
               numer <= {numer[ITER_L-2:0], 1'b0};
               rem   <= rem_nxt;
               quo   <= quo_fin[ITER_L-2:0];
               cnt   <= cnt + CW'(1);
               if (last_step) begin
                  O_QUOTIENT <= result;
                  O_DZ       <= dz;
               end
            end
            default: ;
         endcase
      end
   end

   assign O_VLD      = (state == DONE);
   assign O_DIV_BUSY = (state != IDLE);

endmodule

// File: tb/tb_divider_16.sv
// Scoreboard bench for divider_16: expectations queued at accept, checked on O_VLD.
module tb_divider_16;
   import div_pkg::*;

   typedef struct {
      logic [15:0] q;
      logic        dz;
   } exp_t;

   logic        I_CLK = 1'b0;
   logic        I_RST = 1'b1;
   logic        I_VLD = 1'b0;
   logic [15:0] I_DIVIDEND = '0;
   logic [15:0] I_DIVISOR  = '0;
   logic        O_VLD, O_DIV_BUSY, O_DZ;
   logic [15:0] O_QUOTIENT;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic vld_prev = 1'b0;

   divider_16 dut (
      .I_CLK      (I_CLK),
      .I_RST      (I_RST),
      .I_VLD      (I_VLD),
      .I_DIVIDEND (I_DIVIDEND),
      .I_DIVISOR  (I_DIVISOR),
      .O_VLD      (O_VLD),
      .O_DIV_BUSY (O_DIV_BUSY),
      .O_QUOTIENT (O_QUOTIENT),
      .O_DZ       (O_DZ)
   );

   always #5 I_CLK = ~I_CLK;

   // Reference: integer division of magnitudes, then sign and saturation.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
      exp_t   r;
      longint ma, mb, q;
      logic   neg;
      if (b == 16'h0000) begin
         r.dz = 1'b1;
         r.q  = a[15] ? 16'h8000 : 16'h7FFF;
         return r;
      end
      ma  = a[15] ? (65536 - longint'(a)) : longint'(a);
      mb  = b[15] ? (65536 - longint'(b)) : longint'(b);
      q   = (ma * 8192) / mb;
      neg = a[15] ^ b[15];
      r.dz = 1'b0;
      if (!neg) r.q = (q > 32767) ? 16'h7FFF : 16'(q);
      else      r.q = (q >= 32768) ? 16'h8000 : 16'(-q);
      return r;
   endfunction

   always @(negedge I_CLK) begin
      if (O_VLD) begin
         n_checks++;
         if (vld_prev !== 1'b0) begin
            n_fail++;
            $display("FAIL vld_width: O_VLD high on consecutive cycles, expected one-cycle pulse");
         end
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_vld: O_VLD=1 with no outstanding request, q=%h", O_QUOTIENT);
         end else begin
            mon_e = sb.pop_front();
            if (O_QUOTIENT !== mon_e.q) begin
               n_fail++;
               $display("FAIL quotient: got %h expected %h", O_QUOTIENT, mon_e.q);
            end
            n_checks++;
            if (O_DZ !== mon_e.dz) begin
               n_fail++;
               $display("FAIL dz: got %b expected %b", O_DZ, mon_e.dz);
            end
         end
      end
      vld_prev = O_VLD;
   end

   task automatic wait_idle(input string name);
      int guard = 0;
      @(negedge I_CLK);
      while (O_DIV_BUSY && guard < 100) begin
         @(negedge I_CLK);
         guard++;
      end
      if (O_DIV_BUSY) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_idle_timeout: busy=%b expected 0", name, O_DIV_BUSY);
      end
   endtask

   task automatic wait_vld(input string name, output int edges);
      edges = 1;
      while (edges < 100) begin
         @(posedge I_CLK);
         edges++;
         #1;
         if (O_VLD) break;
      end
      if (!O_VLD) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_vld_timeout: O_VLD=%b expected 1", name, O_VLD);
      end
   endtask

   task automatic run_div(input logic [15:0] dvd, input logic [15:0] dvs,
                          input exp_t e, input bit chk_lat, input string name);
      int edges;
      wait_idle(name);
      I_DIVIDEND = dvd;
      I_DIVISOR  = dvs;
      I_VLD      = 1'b1;
      @(posedge I_CLK);
      sb.push_back(e);
      @(negedge I_CLK);
      I_VLD = 1'b0;
      wait_vld(name, edges);
      if (chk_lat) begin
         n_checks++;
         if (edges !== ITER + 1) begin
            n_fail++;
            $display("FAIL %s_latency: O_VLD after edge %0d expected %0d", name, edges, ITER + 1);
         end
      end
   endtask

   task automatic test_reset();
      #12;
      n_checks += 4;
      if (O_VLD !== 1'b0)       begin n_fail++; $display("FAIL rst_vld: got %b expected 0", O_VLD); end
      if (O_DIV_BUSY !== 1'b0)  begin n_fail++; $display("FAIL rst_busy: got %b expected 0", O_DIV_BUSY); end
      if (O_QUOTIENT !== 16'h0) begin n_fail++; $display("FAIL rst_quotient: got %h expected 0000", O_QUOTIENT); end
      if (O_DZ !== 1'b0)        begin n_fail++; $display("FAIL rst_dz: got %b expected 0", O_DZ); end
      @(negedge I_CLK);
      I_RST = 1'b0;
   endtask

   task automatic test_basic();
      exp_t e;
      e.q = 16'h1000; e.dz = 1'b0;
      run_div(16'h2000, 16'h4000, e, 1'b1, "basic");
      n_checks++;
      if (O_DIV_BUSY !== 1'b1) begin n_fail++; $display("FAIL basic_busy_done: got %b expected 1", O_DIV_BUSY); end
      @(posedge I_CLK);
      #1;
      n_checks += 2;
      if (O_VLD !== 1'b0)      begin n_fail++; $display("FAIL basic_vld_fall: got %b expected 0", O_VLD); end
      if (O_DIV_BUSY !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b expected 0", O_DIV_BUSY); end
      e.q = 16'h1000;
      n_checks++;
      if (O_QUOTIENT !== e.q)  begin n_fail++; $display("FAIL basic_hold: got %h expected %h", O_QUOTIENT, e.q); end
   endtask

   task automatic test_truncation();
      logic [15:0] tv[5][3];
      exp_t e;
      tv = '{'{16'hE000, 16'h4000, 16'hF000},
             '{16'h2000, 16'h6000, 16'h0AAA},
             '{16'hE000, 16'h6000, 16'hF556},
             '{16'h0000, 16'hC000, 16'h0000},
             '{16'hFFFF, 16'h7FFF, 16'h0000}};
      for (int i = 0; i < 5; i++) begin
         e.q = tv[i][2]; e.dz = 1'b0;
         run_div(tv[i][0], tv[i][1], e, 1'b0, "trunc");
      end
   endtask

   task automatic test_saturation();
      logic [15:0] tv[3][3];
      exp_t e;
      tv = '{'{16'h6000, 16'h1000, 16'h7FFF},
             '{16'h6000, 16'hF000, 16'h8000},
             '{16'h8000, 16'h2000, 16'h8000}};
      for (int i = 0; i < 3; i++) begin
         e.q = tv[i][2]; e.dz = 1'b0;
         run_div(tv[i][0], tv[i][1], e, 1'b0, "sat");
      end
   endtask

   task automatic test_div_zero();
      exp_t e;
      e.q = 16'h7FFF; e.dz = 1'b1;
      run_div(16'h2000, 16'h0000, e, 1'b0, "dz_pos");
      e.q = 16'h8000; e.dz = 1'b1;
      run_div(16'hC000, 16'h0000, e, 1'b0, "dz_neg");
      e.q = 16'h7FFF; e.dz = 1'b1;
      run_div(16'h0000, 16'h0000, e, 1'b0, "dz_zero");
      e.q = 16'h1000; e.dz = 1'b0;
      run_div(16'h2000, 16'h4000, e, 1'b0, "dz_clear");
   endtask

   task automatic test_random();
      logic [15:0] a, b;
      for (int i = 0; i < 6; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         run_div(a, b, model(a, b), 1'b0, "rand");
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   cnt, edges;
      wait_idle("b2b");
      I_DIVIDEND = 16'h6000;
      I_DIVISOR  = 16'h4000;
      I_VLD      = 1'b1;
      @(posedge I_CLK);
      e.q = 16'h3000; e.dz = 1'b0;
      sb.push_back(e);
      cnt = 0;
      while (cnt < 100) begin
         @(negedge I_CLK);
         cnt++;
         if (cnt == 5) begin
            I_DIVIDEND = 16'hA000;
            I_DIVISOR  = 16'h2000;
         end
         if (!O_DIV_BUSY) break;
      end
      n_checks++;
      if (cnt !== ITER + 2) begin
         n_fail++;
         $display("FAIL b2b_throughput: busy fell after %0d cycles expected %0d", cnt, ITER + 2);
      end
      e.q = 16'hA000; e.dz = 1'b0;
      sb.push_back(e);
      @(posedge I_CLK);
      @(negedge I_CLK);
      I_VLD = 1'b0;
      wait_vld("b2b", edges);
      n_checks++;
      if (edges !== ITER + 1) begin
         n_fail++;
         $display("FAIL b2b_latency: O_VLD after edge %0d expected %0d", edges, ITER + 1);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   seen = 0;
      wait_idle("rstmid");
      I_DIVIDEND = 16'h2000;
      I_DIVISOR  = 16'h6000;
      I_VLD      = 1'b1;
      @(posedge I_CLK);
      e.q = 16'h0AAA; e.dz = 1'b0;
      sb.push_back(e);
      @(negedge I_CLK);
      I_VLD = 1'b0;
      repeat (10) @(posedge I_CLK);
      #2 I_RST = 1'b1;
      #1;
      void'(sb.pop_front());
      n_checks += 4;
      if (O_VLD !== 1'b0)       begin n_fail++; $display("FAIL rstmid_vld: got %b expected 0", O_VLD); end
      if (O_DIV_BUSY !== 1'b0)  begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", O_DIV_BUSY); end
      if (O_QUOTIENT !== 16'h0) begin n_fail++; $display("FAIL rstmid_quotient: got %h expected 0000", O_QUOTIENT); end
      if (O_DZ !== 1'b0)        begin n_fail++; $display("FAIL rstmid_dz: got %b expected 0", O_DZ); end
      @(posedge I_CLK);
      @(negedge I_CLK);
      I_RST = 1'b0;
      repeat (40) begin
         @(negedge I_CLK);
         if (O_VLD) seen++;
      end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_vld: saw %0d pulses expected 0", seen); end
      e.q = 16'h1000; e.dz = 1'b0;
      run_div(16'h2000, 16'h4000, e, 1'b1, "rstmid_after");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_truncation();
      test_saturation();
      test_div_zero();
      test_random();
      test_back_to_back();
      test_reset_mid();
      repeat (3) @(negedge I_CLK);
      n_checks++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d results outstanding expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
